// File: rtl/adc_apb_sequencer.sv
// adc_apb_sequencer: APB initiator that runs PLL/AMUX/trigger writes, polls ADC status and reads the measurement (ADC_SEQ_TIMEOUT_EN enables the status-poll timeout)
module adc_apb_sequencer #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int POLL_LIMIT = 1023
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] pll_cfg,
  input  logic [DATA_WIDTH-1:0] amux_sel,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);
  typedef enum logic [2:0] {S_IDLE, S_WR_PLL, S_WR_AMUX, S_WR_TRIG, S_RD_STATUS, S_RD_MEAS} seq_t;
  typedef enum logic [1:0] {P_SETUP, P_ACCESS, P_GAP} phase_t;
  localparam logic [ADDR_WIDTH-1:0] A_PLL    = ADDR_WIDTH'('h100);
  localparam logic [ADDR_WIDTH-1:0] A_AMUX   = ADDR_WIDTH'('h101);
  localparam logic [ADDR_WIDTH-1:0] A_TRIG   = ADDR_WIDTH'('h102);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'('h001);
  localparam logic [ADDR_WIDTH-1:0] A_MEAS   = ADDR_WIDTH'('h002);
  seq_t                  seq, seq_nx;
  phase_t                ph, ph_nx;
  logic [DATA_WIDTH-1:0] pll_q, amux_q, pll_nx, amux_nx, result_nx;
  logic                  rv_nx, err_nx;
  logic [1:0]            code_nx;
  logic                  xfer_done, poll_timeout;
  if (POLL_LIMIT < 1) begin : g_bad_poll_limit
    $error("POLL_LIMIT must be at least 1");
  end
  assign busy      = seq != S_IDLE;
  assign PSEL      = busy && ph != P_GAP;
  assign PENABLE   = busy && ph == P_ACCESS;
  assign xfer_done = PENABLE && PREADY;
`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int CW = ($clog2(POLL_LIMIT + 1) > 10) ? $clog2(POLL_LIMIT + 1) : 10;
  logic [CW-1:0] poll_cnt;
  // count not-done status reads; restart when polling begins after the trigger write
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) poll_cnt <= '0;
    else if (seq == S_WR_TRIG && xfer_done) poll_cnt <= '0;
    else if (seq == S_RD_STATUS && xfer_done && !PRDATA[0]) poll_cnt <= poll_cnt + 1'b1;
  assign poll_timeout = poll_cnt >= CW'(POLL_LIMIT - 1);
`else
  assign poll_timeout = 1'b0;
`endif
  // transfer attributes follow the sequence step; the GAP cycle already shows the next step with PSEL low
  always_comb begin
    PWRITE = seq inside {S_WR_PLL, S_WR_AMUX, S_WR_TRIG};
    PADDR  = seq == S_WR_PLL    ? A_PLL    :
             seq == S_WR_AMUX   ? A_AMUX   :
             seq == S_WR_TRIG   ? A_TRIG   :
             seq == S_RD_STATUS ? A_STATUS :
             seq == S_RD_MEAS   ? A_MEAS   : '0;
    PWDATA = seq == S_WR_PLL  ? pll_q  :
             seq == S_WR_AMUX ? amux_q :
             seq == S_WR_TRIG ? DATA_WIDTH'(1) : '0;
  end
  // sequence and APB phase next-state, result capture and strobes
  always_comb begin
    seq_nx    = seq;
    ph_nx     = ph;
    pll_nx    = pll_q;
    amux_nx   = amux_q;
    result_nx = result;
    rv_nx     = 1'b0;
    err_nx    = 1'b0;
    code_nx   = err_code;
    if (seq == S_IDLE) begin
      if (start) begin
        seq_nx  = S_WR_PLL;
        ph_nx   = P_SETUP;
        pll_nx  = pll_cfg;
        amux_nx = amux_sel;
        code_nx = 2'b00;
      end
    end else if (ph == P_SETUP) begin
      ph_nx = P_ACCESS;
    end else if (ph == P_GAP) begin
      ph_nx = P_SETUP;
    end else if (PREADY) begin
      ph_nx = P_GAP;
      if (PSLVERR) begin
        seq_nx  = S_IDLE;
        err_nx  = 1'b1;
        code_nx = 2'b01;
      end else if (seq == S_RD_MEAS) begin
        seq_nx    = S_IDLE;
        result_nx = PRDATA;
        rv_nx     = 1'b1;
      end else if (seq == S_RD_STATUS) begin
        if (PRDATA[0]) seq_nx = S_RD_MEAS;
        else if (poll_timeout) begin
          seq_nx  = S_IDLE;
          err_nx  = 1'b1;
          code_nx = 2'b10;
        end
      end else begin
        seq_nx = seq == S_WR_PLL ? S_WR_AMUX : seq == S_WR_AMUX ? S_WR_TRIG : S_RD_STATUS;
      end
    end
  end
  // state and output registers
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      seq          <= S_IDLE;
      ph           <= P_SETUP;
      pll_q        <= '0;
      amux_q       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      err_code     <= 2'b00;
    end else begin
      seq          <= seq_nx;
      ph           <= ph_nx;
      pll_q        <= pll_nx;
      amux_q       <= amux_nx;
      result       <= result_nx;
      result_valid <= rv_nx;
      error        <= err_nx;
      err_code     <= code_nx;
    end
endmodule

// File: tb/tb_adc_apb_sequencer.sv
// tb_adc_apb_sequencer: directed and randomized checks of the ADC APB sequencer against a reactive APB slave model
`timescale 1ns/1ps
module tb_adc_apb_sequencer;
  logic        PCLK = 0, PRESET = 0, start = 0;
  logic [31:0] pll_cfg = 0, amux_sel = 0;
  logic [31:0] result, PWDATA, PRDATA;
  logic        busy, result_valid, error, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [1:0]  err_code;
  logic [11:0] PADDR;
  int n_cmp = 0, n_bad = 0;
  typedef struct {logic [11:0] a; logic w; logic [31:0] d;} xfer_t;
  xfer_t log_q[$], exp_q[$];
  int wait_lo = 0, wait_hi = 0, done_on = 1, err_addr = -1, tot_waits = 0, status_cnt = 0;
  bit force_done = 0;
  logic [31:0] meas_val = 0, last_meas = 0;

  always #5 PCLK = ~PCLK;

  adc_apb_sequencer #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .POLL_LIMIT(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .start(start), .pll_cfg(pll_cfg), .amux_sel(amux_sel),
    .busy(busy), .result(result), .result_valid(result_valid), .error(error), .err_code(err_code),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // APB slave: random wait states, status done after done_on polls, PSLVERR on err_addr, logs completions
  initial begin
    logic [11:0] s_a;
    logic        s_w;
    logic [31:0] s_d, junk;
    int          wcnt, cur_w;
    bit          dn;
    PREADY = 0; PSLVERR = 0; PRDATA = '0;
    wcnt = 0; cur_w = 0; s_a = '0; s_w = 0; s_d = '0;
    forever begin
      @(negedge PCLK);
      PREADY = 0; PSLVERR = 0;
      if (PSEL && !PENABLE) begin
        s_a = PADDR; s_w = PWRITE; s_d = PWDATA;
        wcnt = int'($urandom_range(wait_hi, wait_lo)); cur_w = wcnt;
      end else if (PSEL && PENABLE) begin
        chk("apb_stable", 64'({PADDR, PWRITE, PWDATA}), 64'({s_a, s_w, s_d}));
        if (wcnt > 0) wcnt--;
        else begin
          junk = $urandom;
          dn = force_done || (done_on != 0 && status_cnt + 1 >= done_on);
          PREADY = 1;
          PSLVERR = int'(PADDR) == err_addr;
          PRDATA = PADDR == 12'h001 ? {junk[31:1], dn} : PADDR == 12'h002 ? meas_val : junk;
          log_q.push_back('{PADDR, PWRITE, PWDATA});
          tot_waits += cur_w;
          if (PADDR == 12'h001) status_cnt++;
          if (PADDR == 12'h102 && PWRITE) status_cnt = 0;
        end
      end
    end
  end

  task automatic build_exp(input logic [31:0] pll, input logic [31:0] amux, input int n_wr, input int polls, input bit meas);
    exp_q.delete();
    if (n_wr > 0) exp_q.push_back('{12'h100, 1'b1, pll});
    if (n_wr > 1) exp_q.push_back('{12'h101, 1'b1, amux});
    if (n_wr > 2) exp_q.push_back('{12'h102, 1'b1, 32'h1});
    repeat (polls) exp_q.push_back('{12'h001, 1'b0, 32'h0});
    if (meas) exp_q.push_back('{12'h002, 1'b0, 32'h0});
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, "_xfer_count"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s_xfer%0d", tag, i), 64'({log_q[i].a, log_q[i].w, log_q[i].d}),
          64'({exp_q[i].a, exp_q[i].w, exp_q[i].d}));
  endtask

  task automatic start_seq(input logic [31:0] pll, input logic [31:0] amux);
    @(negedge PCLK);
    log_q.delete(); tot_waits = 0;
    pll_cfg = pll; amux_sel = amux; start = 1;
    @(negedge PCLK);
    start = 0;
  endtask

  task automatic wait_end(input int n0, output int lat);
    int n = n0;
    while (!(result_valid || error) && n < 4000) begin
      @(negedge PCLK);
      n++;
    end
    lat = n - 1;
    chk("end_strobe_seen", 64'(result_valid | error), 64'd1);
  endtask

  task automatic good_run(input string tag, input logic [31:0] pll, input logic [31:0] amux);
    int lat;
    meas_val = $urandom;
    start_seq(pll, amux);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_errcode_clr"}, 64'(err_code), 64'd0);
    wait_end(1, lat);
    chk({tag, "_rv"}, 64'(result_valid), 64'd1);
    chk({tag, "_err"}, 64'(error), 64'd0);
    chk({tag, "_result"}, 64'(result), 64'(meas_val));
    chk({tag, "_latency"}, 64'(lat), 64'(14 + 3 * (done_on - 1) + tot_waits));
    build_exp(pll, amux, 3, done_on, 1);
    cmp_log(tag);
    last_meas = meas_val;
    @(negedge PCLK);
    chk({tag, "_rv_one_cycle"}, 64'({result_valid, busy}), 64'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] p, q;
    #2 PRESET = 1;
    repeat (3) @(negedge PCLK);
    chk("reset_ctrl", 64'({PSEL, PENABLE, PWRITE, busy, result_valid, error, err_code}), 64'd0);
    chk("reset_data", 64'({PADDR, PWDATA, result}), 64'd0);
    PRESET = 0;

    // basic zero-wait measurement, done on first poll
    wait_lo = 0; wait_hi = 0; done_on = 1; meas_val = 32'hA5A5_0123;
    start_seq(32'h11, 32'h3);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_end(1, lat);
    chk("t1_latency", 64'(lat), 64'd14);
    chk("t1_rv", 64'({result_valid, error}), 64'b10);
    chk("t1_result", 64'(result), 64'hA5A5_0123);
    build_exp(32'h11, 32'h3, 3, 1, 1);
    cmp_log("t1");
    last_meas = meas_val;
    @(negedge PCLK);
    chk("t1_rv_one_cycle", 64'({result_valid, busy}), 64'd0);

    // two wait states on every access, done on third poll: 7 transfers x 2 waits
    wait_lo = 2; wait_hi = 2; done_on = 3;
    good_run("t2", $urandom, $urandom);
    chk("t2_waits", 64'(tot_waits), 64'd14);

    // randomized waits, poll counts and data
    for (int k = 0; k < 5; k++) begin
      wait_lo = 0; wait_hi = int'($urandom_range(3, 0)); done_on = int'($urandom_range(4, 1));
      good_run($sformatf("rnd%0d", k), $urandom, $urandom);
    end

    // PSLVERR on the AMUX write aborts before the trigger write
    wait_lo = 0; wait_hi = 1; done_on = 1; err_addr = 'h101;
    p = $urandom; q = $urandom;
    start_seq(p, q);
    wait_end(1, lat);
    chk("slverr_strobe", 64'({result_valid, error}), 64'b01);
    chk("slverr_code", 64'(err_code), 64'd1);
    chk("slverr_result_kept", 64'(result), 64'(last_meas));
    chk("slverr_latency", 64'(lat), 64'(5 + tot_waits));
    repeat (6) @(negedge PCLK);
    chk("slverr_quiet", 64'({busy, error, PSEL}), 64'd0);
    chk("slverr_code_held", 64'(err_code), 64'd1);
    build_exp(p, q, 2, 0, 0);
    cmp_log("slverr");
    err_addr = -1;

    // start while busy is ignored; start in the result_valid cycle is accepted
    wait_lo = 0; wait_hi = 0; done_on = 2; meas_val = $urandom;
    p = $urandom; q = $urandom;
    start_seq(p, q);
    chk("rs_errcode_clr", 64'(err_code), 64'd0);
    repeat (3) @(negedge PCLK);
    start = 1; pll_cfg = ~p;
    @(negedge PCLK);
    start = 0;
    wait_end(5, lat);
    chk("rs_latency", 64'(lat), 64'd17);
    build_exp(p, q, 3, 2, 1);
    cmp_log("rs_first");
    last_meas = meas_val;
    p = $urandom; q = $urandom;
    log_q.delete(); tot_waits = 0;
    pll_cfg = p; amux_sel = q; start = 1;
    @(negedge PCLK);
    start = 0;
    chk("rs_reaccept_setup", 64'({PSEL, PENABLE, PADDR}), 64'({2'b10, 12'h100}));
    chk("rs_reaccept_pwdata", 64'(PWDATA), 64'(p));
    meas_val = $urandom;
    wait_end(1, lat);
    chk("rs_second_latency", 64'(lat), 64'd17);
    chk("rs_second_result", 64'(result), 64'(meas_val));
    build_exp(p, q, 3, 2, 1);
    cmp_log("rs_second");
    last_meas = meas_val;

`ifdef ADC_SEQ_TIMEOUT_EN
    // status never done: POLL_LIMIT reads then timeout
    wait_lo = 0; wait_hi = 0; done_on = 0;
    p = $urandom; q = $urandom;
    start_seq(p, q);
    wait_end(1, lat);
    chk("to_strobe", 64'({result_valid, error}), 64'b01);
    chk("to_code", 64'(err_code), 64'd2);
    chk("to_latency", 64'(lat), 64'd20);
    chk("to_result_kept", 64'(result), 64'(last_meas));
    build_exp(p, q, 3, 4, 0);
    cmp_log("to");
`else
    // status never done: polling continues with no error until released
    begin
      int n;
      bit err_seen;
      n = 1; err_seen = 0;
      wait_lo = 0; wait_hi = 0; done_on = 0; meas_val = $urandom;
      start_seq($urandom, $urandom);
      while (status_cnt < 105 && n < 1000) begin
        @(negedge PCLK);
        n++;
        if (error) err_seen = 1;
      end
      chk("nto_polls", 64'(status_cnt >= 105), 64'd1);
      chk("nto_no_error", 64'({err_seen, busy}), 64'b01);
      force_done = 1;
      wait_end(n, lat);
      force_done = 0;
      chk("nto_finish", 64'({result_valid, error, err_code}), 64'b1000);
      chk("nto_result", 64'(result), 64'(meas_val));
      last_meas = meas_val;
    end
`endif

    // reset during the trigger-write access abandons the transfer
    wait_lo = 3; wait_hi = 3; done_on = 1;
    start_seq($urandom, $urandom);
    begin
      int n;
      n = 1;
      while (!(PSEL && PENABLE && PADDR == 12'h102) && n < 200) begin
        @(negedge PCLK);
        n++;
      end
    end
    chk("rst_reached_trig", 64'({PSEL, PENABLE, PADDR}), 64'({2'b11, 12'h102}));
    #1 PRESET = 1;
    #1;
    chk("rst_async_drop", 64'({PSEL, PENABLE, busy, result_valid, error}), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    @(negedge PCLK);
    chk("rst_no_strobe", 64'({result_valid, error, PSEL}), 64'd0);
    PRESET = 0;
    wait_lo = 0; wait_hi = 2; done_on = 2;
    good_run("post_rst", $urandom, $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
